// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receive engine with configurable word length,
// parity, stop bits and bit order, feeding a one-entry valid/ready output buffer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : receive enable; low aborts any frame in progress
//   rx          : asynchronous serial input, idle high
//   tick        : one-clk strobe at baud*OVERSAMPLE
//   data/valid/ready          : buffered word and handshake
//   frame_err/parity_err      : error flags qualifying the buffered word
//   overrun     : sticky, a completed frame was dropped because the buffer was full
//   busy        : receiver is inside a frame
module uart_rx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rx,
    input  logic                 tick,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TCW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = $clog2(DATA_BITS + 1);
    localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY != 0);
    localparam bit ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic                   rx_meta;
    logic                   rx_s;
    logic [TCW-1:0]         tick_cnt;
    logic [BCW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   ferr_pend;
    logic                   perr_pend;
    logic                   half_c;
    logic                   full_c;
    logic                   sample_c;
    logic                   commit_c;
    logic                   accept_c;

    // Two-flop synchroniser for the pad input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign half_c   = tick && (tick_cnt == HALF_LAST);
    assign full_c   = tick && (tick_cnt == FULL_LAST);
    assign accept_c = valid && ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and sample/commit strobes
    always_comb begin
        state_nx = state;
        sample_c = 1'b0;
        commit_c = 1'b0;
        if (!en) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) state_nx = S_START;
                end
                S_START: begin
                    // Mid start bit: a high level here means the low was a glitch
                    if (half_c) state_nx = rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (full_c) begin
                        sample_c = 1'b1;
                        if (bit_cnt == DATA_LAST) state_nx = HAS_PARITY ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (full_c) begin
                        sample_c = 1'b1;
                        state_nx = S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is not missed
                    if (full_c) begin
                        sample_c = 1'b1;
                        if (bit_cnt == STOP_LAST) begin
                            commit_c = 1'b1;
                            state_nx = S_IDLE;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Tick/bit counters, shift register and pending error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ferr_pend <= 1'b0;
            perr_pend <= 1'b0;
        end else begin
            if ((state_nx != state) || (state == S_IDLE)) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= (tick_cnt == FULL_LAST) ? '0 : tick_cnt + TCW'(1);
            end

            if (state_nx != state) begin
                bit_cnt <= '0;
            end else if (sample_c) begin
                bit_cnt <= bit_cnt + BCW'(1);
            end

            if (sample_c && (state == S_DATA)) begin
                if (MSB_FIRST != 0) begin
                    shreg <= {shreg[DATA_BITS-2:0], rx_s};
                end else begin
                    shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                end
            end

            if (state == S_START) begin
                ferr_pend <= 1'b0;
                perr_pend <= 1'b0;
            end else begin
                if (sample_c && (state == S_PARITY)) perr_pend <= (^shreg) ^ rx_s ^ ODD_PARITY;
                if (sample_c && (state == S_STOP) && !rx_s) ferr_pend <= 1'b1;
            end
        end
    end

    // Output buffer, handshake and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (commit_c && (!valid || ready)) begin
                data       <= shreg;
                frame_err  <= ferr_pend | ~rx_s;
                parity_err <= perr_pend;
                valid      <= 1'b1;
            end else if (accept_c) begin
                valid <= 1'b0;
            end

            if (commit_c && valid && !ready) begin
                overrun <= 1'b1;
            end else if (accept_c) begin
                overrun <= 1'b0;
            end

            busy <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1 LSB-first; 7 bits odd
// parity two stops; 5 bits even parity MSB-first at 4x oversampling).
module tb_uart_rx_param;

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       tick;
    logic       ready;
    logic [2:0] rx_v;
    logic [2:0] valid_v, fe_v, pe_v, ov_v, busy_v;
    logic [7:0] data0;
    logic [6:0] data1;
    logic [4:0] data2;
    logic [8:0] d_a [3];

    exp_t       expq [3][$];
    logic       exp_ov [3];
    int         ndeliv [3];
    logic [8:0] last_d [3];
    logic       last_fe [3];
    logic       last_pe [3];
    int         busy_ticks;
    int         nvec;
    int         nfail;

    assign d_a[0] = 9'(data0);
    assign d_a[1] = 9'(data1);
    assign d_a[2] = 9'(data2);

    always #5 clk = ~clk;

    uart_rx_param u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .rx(rx_v[0]), .tick(tick),
        .data(data0), .valid(valid_v[0]), .ready(ready), .frame_err(fe_v[0]),
        .parity_err(pe_v[0]), .overrun(ov_v[0]), .busy(busy_v[0])
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(2), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .rx(rx_v[1]), .tick(tick),
        .data(data1), .valid(valid_v[1]), .ready(ready), .frame_err(fe_v[1]),
        .parity_err(pe_v[1]), .overrun(ov_v[1]), .busy(busy_v[1])
    );

    uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(4), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(1)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .rx(rx_v[2]), .tick(tick),
        .data(data2), .valid(valid_v[2]), .ready(ready), .frame_err(fe_v[2]),
        .parity_err(pe_v[2]), .overrun(ov_v[2]), .busy(busy_v[2])
    );

    function automatic int cfg_bits(input int id);
        case (id)
            0: return 8;
            1: return 7;
            default: return 5;
        endcase
    endfunction

    function automatic int cfg_os(input int id);
        return (id == 2) ? 4 : 16;
    endfunction

    function automatic int cfg_par(input int id);
        case (id)
            0: return 0;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_stop(input int id);
        return (id == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Free-running baud*OVERSAMPLE strobe, high every other clock
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = ~tick;
        end
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input int id, input logic b, input int nt);
        @(negedge clk);
        rx_v[id] = b;
        wait_ticks(nt);
    endtask

    // Build a frame from the line-format rules and predict its outcome.
    // abort_after >= 0 drops en after that many data bits.
    task automatic send_frame(input int id, input int val, input bit flip_par,
                              input logic [1:0] stop_low, input int abort_after);
        int         n, os, par, nstop, ones;
        logic       pbit;
        logic [8:0] v;
        exp_t       e;
        n     = cfg_bits(id);
        os    = cfg_os(id);
        par   = cfg_par(id);
        nstop = cfg_stop(id);
        v     = 9'(val) & 9'((1 << n) - 1);
        ones  = $countones(v);
        pbit  = (par == 2) ? 1'((ones % 2) == 0) : 1'((ones % 2) == 1);
        if (flip_par) pbit = ~pbit;
        e.data = v;
        e.fe   = stop_low[0] | ((nstop == 2) && stop_low[1]);
        e.pe   = flip_par && (par != 0);
        if (abort_after < 0) begin
            if (!ready && (expq[id].size() != 0)) exp_ov[id] = 1'b1;
            else expq[id].push_back(e);
        end
        drive_bit(id, 1'b0, os);
        for (int i = 0; i < n; i++) begin
            if (abort_after == i) begin
                @(negedge clk);
                en = 1'b0;
                rx_v[id] = 1'b1;
                wait_ticks(4);
                @(negedge clk);
                chk($sformatf("u%0d_abort_busy", id), 32'(busy_v[id]), 32'd0);
                en = 1'b1;
                wait_ticks(2 * os);
                return;
            end
            drive_bit(id, (cfg_id_msb(id)) ? v[n-1-i] : v[i], os);
        end
        if (par != 0) drive_bit(id, pbit, os);
        for (int s = 0; s < nstop; s++) begin
            if (stop_low[s]) begin
                drive_bit(id, 1'b0, os / 2 + 2);
                drive_bit(id, 1'b1, os / 2 - 2);
            end else begin
                drive_bit(id, 1'b1, os);
            end
        end
    endtask

    function automatic bit cfg_id_msb(input int id);
        return (id == 2);
    endfunction

    task automatic checkpoint(input int id, input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(valid_v[id]), 32'(expq[id].size() != 0));
        chk({tag, "_overrun"}, 32'(ov_v[id]), 32'(exp_ov[id]));
        chk({tag, "_busy"}, 32'(busy_v[id]), 32'd0);
    endtask

    // Compare process: buffered word against the model whenever valid is high
    always @(negedge clk) begin
        exp_t h;
        #1;
        if (rst_n) begin
            if (busy_v[0] && tick) busy_ticks++;
            for (int i = 0; i < 3; i++) begin
                if (valid_v[i]) begin
                    if (expq[i].size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL u%0d_unexpected_valid: got valid=1 data=0x%0h, expected valid=0", i, d_a[i]);
                    end else begin
                        h = expq[i][0];
                        chk($sformatf("u%0d_word", i), 32'({d_a[i], fe_v[i], pe_v[i]}),
                            32'({h.data, h.fe, h.pe}));
                        if (ready) begin
                            void'(expq[i].pop_front());
                            exp_ov[i]  = 1'b0;
                            ndeliv[i]  = ndeliv[i] + 1;
                            last_d[i]  = d_a[i];
                            last_fe[i] = fe_v[i];
                            last_pe[i] = pe_v[i];
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b0, n0;
        nvec = 0;
        nfail = 0;
        busy_ticks = 0;
        for (int i = 0; i < 3; i++) begin
            exp_ov[i] = 1'b0;
            ndeliv[i] = 0;
            last_d[i] = '0;
            last_fe[i] = 1'b0;
            last_pe[i] = 1'b0;
        end
        rst_n = 1'b0;
        en    = 1'b1;
        ready = 1'b1;
        rx_v  = 3'b111;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({valid_v, fe_v, pe_v, ov_v, busy_v}), 32'd0);
        chk("reset_data", 32'({data0, data1, data2}), 32'd0);
        rst_n = 1'b1;
        wait_ticks(8);

        // 8N1 0xA5, commit must land before the stop bit ends
        n0 = ndeliv[0];
        send_frame(0, 'hA5, 1'b0, 2'b00, -1);
        @(negedge clk);
        chk("8n1_delivered_in_stop", 32'(ndeliv[0] - n0), 32'd1);
        chk("8n1_busy_dropped", 32'(busy_v[0]), 32'd0);
        chk("8n1_data", 32'(last_d[0]), 32'h0A5);
        chk("8n1_flags", 32'({last_fe[0], last_pe[0]}), 32'd0);
        checkpoint(0, "8n1");

        // 4-tick glitch: false start, busy for exactly half a bit
        b0 = busy_ticks;
        n0 = ndeliv[0];
        drive_bit(0, 1'b0, 4);
        drive_bit(0, 1'b1, 24);
        @(negedge clk);
        chk("glitch_busy_ticks", 32'(busy_ticks - b0), 32'd8);
        chk("glitch_no_word", 32'(ndeliv[0] - n0), 32'd0);
        checkpoint(0, "glitch");

        // 7 bits odd parity, two stop bits
        send_frame(1, 'h41, 1'b0, 2'b00, -1);
        wait_ticks(32);
        chk("odd_ok_data", 32'(last_d[1]), 32'h041);
        chk("odd_ok_perr", 32'(last_pe[1]), 32'd0);
        send_frame(1, 'h41, 1'b1, 2'b00, -1);
        wait_ticks(32);
        chk("odd_bad_perr", 32'(last_pe[1]), 32'd1);
        send_frame(1, 'h3C, 1'b0, 2'b10, -1);
        wait_ticks(32);
        chk("stop2_data", 32'(last_d[1]), 32'h03C);
        chk("stop2_ferr", 32'(last_fe[1]), 32'd1);
        checkpoint(1, "u1");

        // 5 bits even parity MSB-first, 4x oversampling
        send_frame(2, 'h13, 1'b0, 2'b00, -1);
        wait_ticks(8);
        chk("msb_data", 32'(last_d[2]), 32'h013);
        chk("msb_perr", 32'(last_pe[2]), 32'd0);
        send_frame(2, 'h0A, 1'b1, 2'b00, -1);
        wait_ticks(8);
        chk("msb_bad_data", 32'(last_d[2]), 32'h00A);
        chk("msb_bad_perr", 32'(last_pe[2]), 32'd1);
        checkpoint(2, "u2");

        // Overrun: second word dropped while the first is held
        @(negedge clk);
        ready = 1'b0;
        send_frame(0, 'h11, 1'b0, 2'b00, -1);
        wait_ticks(16);
        send_frame(0, 'h22, 1'b0, 2'b00, -1);
        wait_ticks(16);
        @(negedge clk);
        chk("ovr_flag", 32'(ov_v[0]), 32'd1);
        chk("ovr_data_held", 32'(data0), 32'h11);
        chk("ovr_valid", 32'(valid_v[0]), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        chk("ovr_clear_valid", 32'(valid_v[0]), 32'd0);
        chk("ovr_clear_flag", 32'(ov_v[0]), 32'd0);
        ready = 1'b1;
        checkpoint(0, "ovr");

        // Enable dropped mid-frame: only the following word arrives
        n0 = ndeliv[0];
        send_frame(0, 'h33, 1'b0, 2'b00, 3);
        send_frame(0, 'h5A, 1'b0, 2'b00, -1);
        wait_ticks(16);
        chk("en_abort_count", 32'(ndeliv[0] - n0), 32'd1);
        chk("en_abort_data", 32'(last_d[0]), 32'h05A);
        checkpoint(0, "en");

        // Asynchronous reset mid-frame with a word buffered
        @(negedge clk);
        ready = 1'b0;
        send_frame(0, 'h77, 1'b0, 2'b00, -1);
        wait_ticks(16);
        drive_bit(0, 1'b0, 16);
        drive_bit(0, 1'b1, 16);
        @(negedge clk);
        chk("pre_rst_busy_valid", 32'({busy_v[0], valid_v[0]}), 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({valid_v, fe_v, pe_v, ov_v, busy_v}), 32'd0);
        chk("rst_mid_data", 32'({data0, data1, data2}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            expq[i].delete();
            exp_ov[i] = 1'b0;
        end
        @(negedge clk);
        rx_v  = 3'b111;
        ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(8);
        checkpoint(0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receive engine; successor to the team's fixed 8-bit, one-sample-per-bit receiver.
- Adds oversampled mid-bit sampling, configurable word length, parity, stop bits and bit order.
- Reports framing and parity errors and holds each word in a one-entry output buffer with a valid/ready handshake and overrun detection.
- Sits between the pad-side serial input and the bus-side register interface of the UART.

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9
OVERSAMPLE, 16, tick strobes per bit period, even, >=4
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked, 1 or 2
MSB_FIRST, 0, 0 = LSB received first, 1 = MSB received first

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
en  in  1  receive enable; low forces IDLE
rx  in  1  serial input, asynchronous to clk, idle high
tick  in  1  one-clk strobe at baud*OVERSAMPLE
data  out  DATA_BITS  received word, valid while valid=1
valid  out  1  output buffer holds a word
ready  in  1  consumer accepts word when valid&&ready
frame_err  out  1  a stop bit sampled low for the buffered word
parity_err  out  1  parity mismatch for the buffered word (0 if PARITY=0)
overrun  out  1  a completed frame was lost because the buffer was full
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_n low, async): all outputs 0; synchroniser flops =1; FSM=IDLE; tick and bit counters 0.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- Tick counter advances only on cycles where tick=1. With en=1 the FSM never acts on non-tick cycles, except the IDLE start detection below.
- IDLE: on any clk where en=1 and rx_s=0, go to START and clear the tick counter.
- START: after OVERSAMPLE/2 ticks, sample rx_s. If 0, go to DATA with the tick counter cleared. If 1, this is a false start: return to IDLE with no flags.
- DATA: sample every OVERSAMPLE ticks, i.e. mid-bit. Shift into the word per MSB_FIRST. After DATA_BITS samples, go to PARITY if PARITY!=0, else STOP.
- PARITY: sample one bit. Error if the XOR of payload and parity bit is 1 (even) or 0 (odd).
- STOP: take STOP_BITS samples. Any 0 sets the pending frame error. On the final stop sample, commit and go to IDLE immediately (mid-stop-bit), allowing back-to-back frames.
- Commit, visible the clk after the final stop-sample tick:
  - If the buffer is empty, or valid&&ready in that same cycle: load data and flags, valid=1.
  - Else drop the new frame, set overrun=1, and leave the buffered word unchanged.
- Handshake: data and flags are stable while valid=1. valid&&ready with no simultaneous commit clears valid. data keeps its last value.
- overrun is sticky. It clears on the next accepted handshake (valid&&ready), unless a second overrun occurs in that same cycle, in which case it stays 1.
- Frames with errors are still delivered; consumers qualify them with the flags.
- en low in any state: FSM to IDLE next clk and the partial frame is discarded. The output buffer, its flags and overrun are unaffected, and handshakes still work.
- busy=1 in START, DATA, PARITY and STOP.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 LSB-first with ready=1 -> one-cycle valid, data=0xA5, frame_err=0, parity_err=0, overrun=0; busy drops mid-stop-bit.
- 4-tick low glitch on idle rx -> START reached, false start, back to IDLE; valid stays 0, busy high for about 8 ticks only.
- PARITY=2, 7 data bits, send 0x41 with parity bit 1 -> data=0x41, parity_err=0. Repeat with parity bit 0 -> parity_err=1.
- STOP_BITS=2, second stop bit driven 0 for 0x3C -> data=0x3C, frame_err=1, valid=1.
- ready=0, send 0x11 then 0x22 -> data stays 0x11 and overrun=1. Raise ready for one cycle -> valid=0, overrun=0.
- Drop en after 3 data bits, restore en, send 0x5A -> only 0x5A delivered. Assert rst_n low mid-frame -> all outputs 0 immediately.
